// File: rtl/microsequencer.sv
// Micro-PC sequencer: picks the next control-ROM address (jump, branch-on-Z,
// opcode dispatch, halt) and counts executed micro-cycles.
module microsequencer #(
   parameter int UADDR_W    = 5,
   parameter int FETCH_ADDR = 0,
   parameter int CNT_W      = 16
) (
   input  logic               i_clk,
   input  logic               i_reset,
   input  logic               i_start,
   input  logic               i_stall,
   input  logic [UADDR_W-1:0] i_nxtadd,
   input  logic [1:0]         i_br_type,
   input  logic               i_z_flag,
   input  logic [3:0]         i_opcode,
   input  logic               i_cfg_we,
   input  logic [3:0]         i_cfg_idx,
   input  logic [UADDR_W-1:0] i_cfg_data,
   output logic [UADDR_W-1:0] o_upc,
   output logic               o_rom_en,
   output logic               o_busy,
   output logic               o_halted,
   output logic               o_cfg_rej,
   output logic [CNT_W-1:0]   o_ucycles
);

   localparam logic [UADDR_W-1:0] LP_FETCH = UADDR_W'(FETCH_ADDR);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_HALT} state_t;

   typedef enum logic [1:0] {
      BR_JUMP     = 2'b00,
      BR_ZERO     = 2'b01,
      BR_DISPATCH = 2'b10,
      BR_HALT     = 2'b11
   } br_t;

   state_t               r_state, w_state_nxt;
   logic [UADDR_W-1:0]   r_upc, w_upc_nxt;
   logic [CNT_W-1:0]     r_ucycles, w_ucycles_nxt;
   logic [UADDR_W-1:0]   r_dtab [16];
   logic                 r_cfg_rej;
   logic                 w_exec;
   logic                 w_cfg_ok;

   assign w_exec   = (r_state == S_RUN) && !i_stall;
   assign w_cfg_ok = i_cfg_we && (r_state != S_RUN);

   always_comb begin
      w_state_nxt   = r_state;
      w_upc_nxt     = r_upc;
      w_ucycles_nxt = r_ucycles;
      case (r_state)
         S_IDLE: begin
            if (i_start) begin
               w_state_nxt   = S_RUN;
               w_upc_nxt     = LP_FETCH;
               w_ucycles_nxt = '0;
            end
         end
         S_RUN: begin
            if (w_exec) begin
               case (br_t'(i_br_type))
                  BR_JUMP:     w_upc_nxt = i_nxtadd;
                  BR_ZERO:     w_upc_nxt = i_z_flag ? i_nxtadd : r_upc + 1'b1;
                  BR_DISPATCH: w_upc_nxt = r_dtab[i_opcode];
                  BR_HALT:     w_state_nxt = S_HALT;
                  default:     w_upc_nxt = r_upc;
               endcase
               if (r_ucycles != '1) w_ucycles_nxt = r_ucycles + 1'b1;
            end
         end
         S_HALT: begin
            // Resume keeps the cycle count so a halted program can be profiled end to end.
            if (i_start) begin
               w_state_nxt = S_RUN;
               w_upc_nxt   = LP_FETCH;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         r_state   <= S_IDLE;
         r_upc     <= LP_FETCH;
         r_ucycles <= '0;
         r_cfg_rej <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_upc     <= w_upc_nxt;
         r_ucycles <= w_ucycles_nxt;
         r_cfg_rej <= i_cfg_we && (r_state == S_RUN);
      end
   end

   always_ff @(posedge i_clk or posedge i_reset) begin
      if (i_reset) begin
         for (int i = 0; i < 16; i++) r_dtab[i] <= LP_FETCH;
      end else if (w_cfg_ok) begin
         r_dtab[i_cfg_idx] <= i_cfg_data;
      end
   end

   assign o_upc     = r_upc;
   assign o_rom_en  = w_exec;
   assign o_busy    = (r_state == S_RUN);
   assign o_halted  = (r_state == S_HALT);
   assign o_cfg_rej = r_cfg_rej;
   assign o_ucycles = r_ucycles;

endmodule

// File: tb/tb_microsequencer.sv
// Self-checking bench for microsequencer: directed scenarios plus randomized
// traffic against a behavioural model of the sequencing rules.
module tb_microsequencer;

   logic       clk = 1'b0;
   logic       rst, start, stall, z, cfg_we;
   logic [4:0] nxtadd, cfg_data, upc;
   logic [1:0] br;
   logic [3:0] op, cfg_idx;
   logic       rom_en, busy, halted, cfg_rej;
   logic [15:0] ucycles;

   int n_chk  = 0;
   int n_fail = 0;

   // model: mode 0 idle, 1 run, 2 halt
   int m_mode, m_upc, m_cyc;
   int m_dtab [16];
   bit m_rej;

   microsequencer #(.UADDR_W(5), .FETCH_ADDR(0), .CNT_W(16)) dut (
      .i_clk(clk), .i_reset(rst), .i_start(start), .i_stall(stall),
      .i_nxtadd(nxtadd), .i_br_type(br), .i_z_flag(z), .i_opcode(op),
      .i_cfg_we(cfg_we), .i_cfg_idx(cfg_idx), .i_cfg_data(cfg_data),
      .o_upc(upc), .o_rom_en(rom_en), .o_busy(busy), .o_halted(halted),
      .o_cfg_rej(cfg_rej), .o_ucycles(ucycles)
   );

   always #5 clk = ~clk;

   task automatic m_reset();
      m_mode = 0; m_upc = 0; m_cyc = 0; m_rej = 0;
      for (int i = 0; i < 16; i++) m_dtab[i] = 0;
   endtask

   task automatic m_step();
      bit rej;
      rej = 0;
      if (rst) begin
         m_reset();
         return;
      end
      if (m_mode == 1) begin
         rej = cfg_we;
         if (!stall) begin
            if (br == 2'd0) m_upc = nxtadd;
            else if (br == 2'd1) m_upc = z ? int'(nxtadd) : (m_upc + 1) % 32;
            else if (br == 2'd2) m_upc = m_dtab[op];
            else m_mode = 2;
            m_cyc = (m_cyc + 1 > 65535) ? 65535 : m_cyc + 1;
         end
      end else begin
         if (cfg_we) m_dtab[cfg_idx] = cfg_data;
         if (start) begin
            if (m_mode == 0) m_cyc = 0;
            m_mode = 1;
            m_upc  = 0;
         end
      end
      m_rej = rej;
   endtask

   task automatic quiet();
      start = 0; stall = 0; z = 0; cfg_we = 0; nxtadd = 0; br = 0;
      op = 0; cfg_idx = 0; cfg_data = 0;
   endtask

   task automatic tick();
      @(posedge clk);
      m_step();
      #1;
   endtask

   task automatic do_reset();
      rst = 1; #3; m_reset();
      @(posedge clk); #1;
      rst = 0;
      quiet();
   endtask

   task automatic test_reset();
      quiet();
      rst = 1;
      #12;
      m_reset();
      n_chk++; if (upc !== 5'd0) begin n_fail++; $display("FAIL reset_upc got %0d want 0", upc); end
      n_chk++; if (ucycles !== 16'd0) begin n_fail++; $display("FAIL reset_ucycles got %0d want 0", ucycles); end
      n_chk++; if ({rom_en, busy, halted, cfg_rej} !== 4'b0000) begin
         n_fail++; $display("FAIL reset_flags got %b want 0000", {rom_en, busy, halted, cfg_rej});
      end
      @(posedge clk); #1;
      rst = 0;
   endtask

   task automatic test_start_jump();
      start = 1; tick(); start = 0;
      n_chk++; if (upc !== 5'd0 || busy !== 1'b1) begin
         n_fail++; $display("FAIL start upc=%0d busy=%b want 0/1", upc, busy);
      end
      br = 2'd0; nxtadd = 5'd7; tick();
      n_chk++; if (upc !== 5'd7) begin n_fail++; $display("FAIL jump got %0d want 7", upc); end
      n_chk++; if (ucycles !== 16'(m_cyc)) begin n_fail++; $display("FAIL jump_cyc got %0d want %0d", ucycles, m_cyc); end
   endtask

   task automatic test_branch_wrap();
      br = 2'd0; nxtadd = 5'd31; tick();
      br = 2'd1; z = 0; nxtadd = 5'd12; tick();
      n_chk++; if (upc !== 5'd0) begin n_fail++; $display("FAIL branch_wrap got %0d want 0", upc); end
      br = 2'd0; nxtadd = 5'd31; tick();
      br = 2'd1; z = 1; nxtadd = 5'd12; tick();
      n_chk++; if (upc !== 5'd12) begin n_fail++; $display("FAIL branch_taken got %0d want 12", upc); end
      quiet();
   endtask

   task automatic test_dispatch();
      do_reset();
      cfg_we = 1; cfg_idx = 4'd5; cfg_data = 5'd20; tick();
      cfg_idx = 4'd6; cfg_data = 5'd25; start = 1; tick();
      quiet();
      br = 2'd2; op = 4'd5; tick();
      n_chk++; if (upc !== 5'd20) begin n_fail++; $display("FAIL dispatch5 got %0d want 20", upc); end
      op = 4'd6; tick();
      n_chk++; if (upc !== 5'd25) begin n_fail++; $display("FAIL dispatch6_sameedge got %0d want 25", upc); end
      op = 4'd3; tick();
      n_chk++; if (upc !== 5'd0) begin n_fail++; $display("FAIL dispatch_default got %0d want 0", upc); end
      quiet();
   endtask

   task automatic test_cfg_reject();
      cfg_we = 1; cfg_idx = 4'd5; cfg_data = 5'd3; br = 2'd0; nxtadd = 5'd1; tick();
      cfg_we = 0;
      n_chk++; if (cfg_rej !== 1'b1) begin n_fail++; $display("FAIL cfg_rej_pulse got %b want 1", cfg_rej); end
      tick();
      n_chk++; if (cfg_rej !== 1'b0) begin n_fail++; $display("FAIL cfg_rej_once got %b want 0", cfg_rej); end
      br = 2'd2; op = 4'd5; tick();
      n_chk++; if (upc !== 5'd20) begin n_fail++; $display("FAIL cfg_rej_dtab got %0d want 20", upc); end
      quiet();
   endtask

   task automatic test_stall();
      logic [15:0] held;
      br = 2'd0; nxtadd = 5'd9; tick();
      held = ucycles;
      stall = 1; nxtadd = 5'd4;
      for (int i = 0; i < 3; i++) begin
         #1;
         n_chk++; if (rom_en !== 1'b0) begin n_fail++; $display("FAIL stall_rom_en cyc%0d got %b want 0", i, rom_en); end
         tick();
         n_chk++; if (upc !== 5'd9 || ucycles !== held) begin
            n_fail++; $display("FAIL stall_hold cyc%0d upc=%0d cyc=%0d want 9/%0d", i, upc, ucycles, held);
         end
      end
      br = 2'd3; tick();
      n_chk++; if (halted !== 1'b0 || busy !== 1'b1) begin
         n_fail++; $display("FAIL stall_halt halted=%b busy=%b want 0/1", halted, busy);
      end
      stall = 0; #1;
      n_chk++; if (rom_en !== 1'b1) begin n_fail++; $display("FAIL unstall_rom_en got %b want 1", rom_en); end
      tick();
      n_chk++; if (halted !== 1'b1 || upc !== 5'd9) begin
         n_fail++; $display("FAIL halt halted=%b upc=%0d want 1/9", halted, upc);
      end
      n_chk++; if (ucycles !== held + 16'd1) begin n_fail++; $display("FAIL halt_cyc got %0d want %0d", ucycles, held + 16'd1); end
      quiet();
   endtask

   task automatic test_halt_restart();
      logic [15:0] held;
      held = ucycles;
      tick();
      n_chk++; if (halted !== 1'b1 || rom_en !== 1'b0) begin
         n_fail++; $display("FAIL halt_stay halted=%b rom_en=%b want 1/0", halted, rom_en);
      end
      start = 1; tick(); start = 0;
      n_chk++; if (upc !== 5'd0 || busy !== 1'b1 || ucycles !== held) begin
         n_fail++; $display("FAIL restart upc=%0d busy=%b cyc=%0d want 0/1/%0d", upc, busy, ucycles, held);
      end
   endtask

   task automatic test_reset_midrun();
      br = 2'd0; nxtadd = 5'd17; tick();
      #3; rst = 1; #1;
      m_reset();
      n_chk++; if (upc !== 5'd0 || busy !== 1'b0 || ucycles !== 16'd0) begin
         n_fail++; $display("FAIL reset_async upc=%0d busy=%b cyc=%0d want 0/0/0", upc, busy, ucycles);
      end
      #13; rst = 0; quiet();
      start = 1; tick(); start = 0;
      n_chk++; if (busy !== 1'b1 || upc !== 5'd0) begin
         n_fail++; $display("FAIL start_after_reset busy=%b upc=%0d want 1/0", busy, upc);
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 600; i++) begin
         start    = ($urandom_range(0, 3) == 0);
         stall    = ($urandom_range(0, 3) == 0);
         z        = 1'($urandom);
         nxtadd   = 5'($urandom);
         br       = ($urandom_range(0, 7) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
         op       = 4'($urandom);
         cfg_we   = ($urandom_range(0, 4) == 0);
         cfg_idx  = 4'($urandom);
         cfg_data = 5'($urandom);
         #1;
         n_chk++; if (rom_en !== (m_mode == 1 && !stall)) begin
            n_fail++; $display("FAIL rnd_rom_en i=%0d got %b", i, rom_en);
         end
         tick();
         n_chk++; if (upc !== 5'(m_upc) || ucycles !== 16'(m_cyc) || busy !== (m_mode == 1) ||
                      halted !== (m_mode == 2) || cfg_rej !== m_rej) begin
            n_fail++;
            $display("FAIL rnd i=%0d upc=%0d/%0d cyc=%0d/%0d busy=%b halt=%b rej=%b/%b mode=%0d",
                     i, upc, m_upc, ucycles, m_cyc, busy, halted, cfg_rej, m_rej, m_mode);
         end
      end
      quiet();
   endtask

   task automatic test_saturate();
      do_reset();
      start = 1; tick(); start = 0;
      br = 2'd0;
      for (int i = 0; i < 65540; i++) begin
         nxtadd = 5'(i);
         tick();
      end
      n_chk++; if (ucycles !== 16'hFFFF || ucycles !== 16'(m_cyc)) begin
         n_fail++; $display("FAIL saturate got %0d want 65535", ucycles);
      end
      quiet();
   endtask

   initial begin
      m_reset();
      test_reset();
      test_start_jump();
      test_branch_wrap();
      test_dispatch();
      test_cfg_reject();
      test_stall();
      test_halt_restart();
      test_reset_midrun();
      test_random();
      test_saturate();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
